// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain with per-stage valid bits, one-place freeze /
// bubble / squash control, and saturating occupancy and event counters.
module pipe_stage_chain #(
  parameter int STAGES       = 5,
  parameter int WIDTH        = 16,
  parameter int BUBBLE_STAGE = 1,
  parameter int CNT_W        = 32,
  localparam int FW          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  input  logic                      imem_resp,
  input  logic                      mem_stall,
  input  logic                      hazard_stall,
  input  logic                      flush,
  input  logic [FW-1:0]             flush_stage,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          bubble_count,
  output logic [CNT_W-1:0]          flush_count,
  output logic [CNT_W-1:0]          retire_count
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  // shift_* is what each stage would load when the pipe moves forward by one.
  logic [STAGES-1:0] shift_v;
  logic [WIDTH-1:0]  shift_d [STAGES];

  logic advance;
  int   f_idx;

  logic stall_ev;
  logic bubble_ev;
  logic flush_ev;
  logic retire_ev;

  assign advance  = imem_resp && !mem_stall;
  assign in_ready = advance && !flush && !hazard_stall;

  always_comb begin
    f_idx = int'(flush_stage);
    if (f_idx > STAGES - 1) f_idx = STAGES - 1;
  end

  always_comb begin
    shift_v    = '0;
    shift_v[0] = in_valid;
    shift_d[0] = in_valid ? in_data : '0;
    for (int k = 1; k < STAGES; k++) begin
      shift_v[k] = valid_q[k-1];
      shift_d[k] = data_q[k-1];
    end
  end

  // Priority: flush over hazard bubble over normal advance; freeze holds all.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];

    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        if (advance) begin
          if (k <= f_idx) begin
            valid_d[k] = 1'b0;
            data_d[k]  = '0;
          end else begin
            valid_d[k] = shift_v[k];
            data_d[k]  = shift_d[k];
          end
        end else if (k < f_idx) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end
      end
    end else if (advance && hazard_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == BUBBLE_STAGE) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end else if (k > BUBBLE_STAGE) begin
          valid_d[k] = shift_v[k];
          data_d[k]  = shift_d[k];
        end
      end
    end else if (advance) begin
      valid_d = shift_v;
      for (int k = 0; k < STAGES; k++) data_d[k] = shift_d[k];
    end
  end

  assign stall_ev  = !advance;
  assign bubble_ev = advance && hazard_stall && !flush;
  assign flush_ev  = flush;
  // A flush reaching the oldest stage squashes its entry instead of retiring it.
  assign retire_ev = advance && valid_q[STAGES-1] && !(flush && (f_idx == STAGES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
      retire_count <= '0;
    end else begin
      if (stall_ev && (stall_cycles != '1))  stall_cycles <= stall_cycles + CNT_W'(1);
      if (bubble_ev && (bubble_count != '1)) bubble_count <= bubble_count + CNT_W'(1);
      if (flush_ev && (flush_count != '1))   flush_count  <= flush_count + CNT_W'(1);
      if (retire_ev && (retire_count != '1)) retire_count <= retire_count + CNT_W'(1);
    end
  end

  always_comb begin
    stage_data = '0;
    for (int k = 0; k < STAGES; k++) stage_data[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: streaming, freeze, bubble, flush, clamp,
// async reset and counter saturation (second instance with 2-bit counters).
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        imem_resp;
  logic        mem_stall;
  logic        hazard_stall;
  logic        flush;
  logic [2:0]  flush_stage;

  logic        in_ready;
  logic [4:0]  stage_valid;
  logic [79:0] stage_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [31:0] stall_cycles, bubble_count, flush_count, retire_count;

  logic        s_in_ready;
  logic [4:0]  s_stage_valid;
  logic [79:0] s_stage_data;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic [1:0]  s_stall, s_bubble, s_flush, s_retire;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.STAGES(5), .WIDTH(16), .BUBBLE_STAGE(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_resp(imem_resp), .mem_stall(mem_stall),
    .hazard_stall(hazard_stall), .flush(flush), .flush_stage(flush_stage),
    .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
    .out_data(out_data), .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .flush_count(flush_count), .retire_count(retire_count)
  );

  pipe_stage_chain #(.STAGES(5), .WIDTH(16), .BUBBLE_STAGE(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .imem_resp(imem_resp), .mem_stall(mem_stall),
    .hazard_stall(hazard_stall), .flush(flush), .flush_stage(flush_stage),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data), .out_valid(s_out_valid),
    .out_data(s_out_data), .stall_cycles(s_stall), .bubble_count(s_bubble),
    .flush_count(s_flush), .retire_count(s_retire)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; imem_resp = 1'b1;
    mem_stall = 1'b0; hazard_stall = 1'b0; flush = 1'b0; flush_stage = '0;
    step(); step();
    chk("rst_valid", stage_valid, 5'b0);
    chk("rst_data", stage_data, 80'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_retire", retire_count, 32'd0);
    rst_n = 1'b1;

    // Stream 0x1001..0x1005; first accept lands on out after 4 more edges.
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 5);
      in_data  = (i < 5) ? 16'(16'h1001 + i) : 16'h0;
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      step();
      chk("stream_out_valid", out_valid, (i >= 4 && i <= 8));
      chk("stream_out_data", out_data, (i >= 4 && i <= 8) ? 16'(16'h1001 + i - 4) : 16'h0);
    end
    chk("stream_retire", retire_count, 32'd5);
    chk("stream_stall", stall_cycles, 32'd0);

    // Freeze for 3 cycles with three entries in flight.
    offer(1'b1, 16'h4001); offer(1'b1, 16'h4002); offer(1'b1, 16'h4003);
    mem_stall = 1'b1; in_data = 16'h4004;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze_in_ready", in_ready, 1'b0);
      step();
      chk("freeze_valid", stage_valid, 5'b00111);
      chk("freeze_data", stage_data, 80'h0000_0000_4001_4002_4003);
    end
    chk("freeze_stall_cycles", stall_cycles, 32'd3);
    mem_stall = 1'b0;
    offer(1'b1, 16'h4004);
    chk("resume_data", stage_data, 80'h0000_4001_4002_4003_4004);
    for (int i = 0; i < 4; i++) begin
      offer(1'b0, 16'h0);
      chk("resume_out_valid", out_valid, 1'b1);
      chk("resume_out_data", out_data, 16'(16'h4001 + i));
    end
    offer(1'b0, 16'h0);
    chk("resume_empty", stage_valid, 5'b0);
    chk("resume_retire", retire_count, 32'd9);

    // Hazard bubble at stage 1.
    offer(1'b1, 16'h2001); offer(1'b1, 16'h2002);
    hazard_stall = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    #1;
    chk("hazard_in_ready", in_ready, 1'b0);
    step();
    hazard_stall = 1'b0;
    chk("hazard_valid", stage_valid, 5'b00101);
    chk("hazard_data", stage_data, 80'h0000_0000_2001_0000_2002);
    chk("hazard_bubble_count", bubble_count, 32'd1);
    for (int i = 0; i < 5; i++) offer(1'b0, 16'h0);
    chk("hazard_drain_valid", stage_valid, 5'b0);
    chk("hazard_retire", retire_count, 32'd11);

    // Full pipe, flush at stage 3 while advancing: stage 4 keeps 0x3001.
    for (int i = 0; i < 5; i++) offer(1'b1, 16'(16'h3000 + i));
    chk("full_data", stage_data, 80'h3000_3001_3002_3003_3004);
    flush = 1'b1; flush_stage = 3'd3; in_valid = 1'b1; in_data = 16'hBEEF;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    chk("flush_valid", stage_valid, 5'b10000);
    chk("flush_data", stage_data, 80'h3001_0000_0000_0000_0000);
    chk("flush_retire", retire_count, 32'd12);
    chk("flush_count1", flush_count, 32'd1);
    flush = 1'b0;

    // Flush and hazard together: flush wins, no bubble counted.
    offer(1'b1, 16'h5001); offer(1'b1, 16'h5002);
    flush = 1'b1; hazard_stall = 1'b1; flush_stage = 3'd1; in_valid = 1'b0;
    step();
    chk("fh_valid", stage_valid, 5'b00100);
    chk("fh_data", stage_data, 80'h0000_0000_5001_0000_0000);
    chk("fh_bubble_count", bubble_count, 32'd1);
    hazard_stall = 1'b0; flush_stage = 3'd7;
    step();
    chk("clamp_valid", stage_valid, 5'b0);
    chk("clamp_data", stage_data, 80'h0);
    chk("clamp_flush_count", flush_count, 32'd3);
    chk("clamp_retire", retire_count, 32'd13);
    flush = 1'b0;

    // Flush while frozen: stages below F clear, F and older hold.
    offer(1'b1, 16'h6001); offer(1'b1, 16'h6002); offer(1'b1, 16'h6003);
    in_valid = 1'b0; mem_stall = 1'b1; flush = 1'b1; flush_stage = 3'd2;
    step();
    chk("frz_flush_valid", stage_valid, 5'b00100);
    chk("frz_flush_data", stage_data, 80'h0000_0000_6001_0000_0000);
    chk("frz_flush_stall", stall_cycles, 32'd4);
    mem_stall = 1'b0; flush = 1'b0;

    // Narrow-counter instance has seen 4 stalls, 4 flushes, 13 retires.
    chk("sat_stall", s_stall, 2'b11);
    chk("sat_flush", s_flush, 2'b11);
    chk("sat_retire", s_retire, 2'b11);
    chk("sat_bubble", s_bubble, 2'b01);

    // Async reset between edges.
    offer(1'b1, 16'h7001); offer(1'b1, 16'h7002);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", stage_valid, 5'b0);
    chk("areset_data", stage_data, 80'h0);
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_stall", stall_cycles, 32'd0);
    chk("areset_flush", flush_count, 32'd0);
    chk("areset_retire", retire_count, 32'd0);
    chk("areset_bubble", bubble_count, 32'd0);
    chk("areset_sat_stall", s_stall, 2'b00);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
